// File: rtl/nocpe_pkg.sv
// Shared definitions for the nocpe1x2 row and its job sequencer.
//   DW / ACC_W   : operand and accumulator widths shared with the row
//   CNT_W        : default beat-counter width for the controller
//   DRAIN_CYCLES : cycles the row needs after the last beat before c0/c1 are final
//   state_t      : controller FSM encoding
package nocpe_pkg;

  localparam int unsigned DW           = 16;
  localparam int unsigned ACC_W        = 32;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/nocpe_skew_pipe.sv
// N-stage, DW-wide delay line with synchronous clear.
// Ports:
//   clk : clock, rising edge
//   clr : synchronous active-high clear of every stage
//   d   : data in
//   q   : data out, d delayed by N clocks
module nocpe_skew_pipe #(
  parameter int unsigned N  = 2,
  parameter int unsigned DW = nocpe_pkg::DW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  import nocpe_pkg::*;

  logic [DW-1:0] stage [N];

  // Shift register; clr wins over shifting.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < int'(N); i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(N); i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[N-1];

endmodule

// File: rtl/nocpe_row_ctrl.sv
// Job sequencer for the 1x2 multiply-accumulate row (nocpe1x2).
// Accepts operand beats, clears the row before each job, skews a1 by one
// extra cycle to meet the row's internal b1 register, waits for the row to
// drain and returns c0/c1 plus the beat count over a valid/ready interface.
// Ports:
//   clk, rst                       : clock; synchronous active-low reset
//   in_valid/in_ready/in_last      : operand beat handshake, last-beat marker
//   in_a0, in_a1, in_b             : operands (PE0 = a0*b, PE1 = a1*b)
//   pe_clr, pe_a0, pe_a1, pe_b0    : to the row (pe_clr drives the row's rst)
//   pe_c0, pe_c1                   : accumulators from the row
//   out_valid/out_ready            : result handshake
//   out_c0, out_c1, out_beats      : captured results and beat count
//   stall_cnt                      : RUN cycles without in_valid
//                                    (only with NOCPE_CTRL_STALL_CNT_EN)
//   busy                           : high whenever not IDLE
module nocpe_row_ctrl #(
  parameter int unsigned DW    = nocpe_pkg::DW,
  parameter int unsigned ACC_W = nocpe_pkg::ACC_W,
  parameter int unsigned CNT_W = nocpe_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_a0,
  input  logic [DW-1:0]    in_a1,
  input  logic [DW-1:0]    in_b,
  input  logic             in_last,
  output logic             pe_clr,
  output logic [DW-1:0]    pe_a0,
  output logic [DW-1:0]    pe_a1,
  output logic [DW-1:0]    pe_b0,
  input  logic [ACC_W-1:0] pe_c0,
  input  logic [ACC_W-1:0] pe_c1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_c0,
  output logic [ACC_W-1:0] out_c1,
  output logic [CNT_W-1:0] out_beats,
`ifdef NOCPE_CTRL_STALL_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic             busy
);

  import nocpe_pkg::*;

  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

  state_t           state;
  state_t           state_d;
  logic             accept;
  logic [DRN_W-1:0] drain_cnt;
  logic             drain_last;
  logic [CNT_W-1:0] beat_cnt;
  logic             capture;
  logic             in_ready_d;
  logic             busy_d;
  logic             pe_clr_d;
  logic             out_valid_d;
  logic             a1_clr;
  logic [DW-1:0]    a1_in;

  assign accept     = (state == ST_RUN) && in_valid;
  assign drain_last = (drain_cnt == DRN_W'(DRAIN_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (in_valid)          state_d = ST_CLEAR;
      ST_CLEAR:                        state_d = ST_RUN;
      ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_last)        state_d = ST_DONE;
      ST_DONE:  if (out_ready)         state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the flopped outputs line up
  // with the state they describe.
  always_comb begin
    in_ready_d  = (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    pe_clr_d    = (state_d == ST_CLEAR);
    out_valid_d = (state_d == ST_DONE);
    capture     = (state == ST_DRAIN) && drain_last;
  end

  // Control outputs, operand registers, counters and result capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      pe_clr    <= 1'b1;
      out_valid <= 1'b0;
      pe_a0     <= '0;
      pe_b0     <= '0;
      drain_cnt <= '0;
      beat_cnt  <= '0;
      out_c0    <= '0;
      out_c1    <= '0;
      out_beats <= '0;
    end else begin
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      pe_clr    <= pe_clr_d;
      out_valid <= out_valid_d;
      // Idle slots feed zeros so the row adds a zero product.
      pe_a0     <= accept ? in_a0 : '0;
      pe_b0     <= accept ? in_b  : '0;
      drain_cnt <= ((state == ST_DRAIN) && !drain_last) ? drain_cnt + DRN_W'(1) : '0;
      if (state_d == ST_CLEAR)      beat_cnt <= '0;
      else if (accept && !(&beat_cnt)) beat_cnt <= beat_cnt + CNT_W'(1);
      if (capture) begin
        out_c0    <= pe_c0;
        out_c1    <= pe_c1;
        out_beats <= beat_cnt;
      end
    end
  end

`ifdef NOCPE_CTRL_STALL_CNT_EN
  // Saturating count of RUN cycles that had no beat offered.
  always_ff @(posedge clk) begin
    if (!rst)                                             stall_cnt <= '0;
    else if (state_d == ST_CLEAR)                         stall_cnt <= '0;
    else if ((state == ST_RUN) && !in_valid && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif

  // a1 needs one more cycle than a0 because b reaches PE1 a cycle late.
  assign a1_clr = !rst || (state_d == ST_CLEAR);
  assign a1_in  = accept ? in_a1 : '0;

  nocpe_skew_pipe #(
    .N  (2),
    .DW (DW)
  ) u_a1_skew (
    .clk (clk),
    .clr (a1_clr),
    .d   (a1_in),
    .q   (pe_a1)
  );

endmodule
